// File: rtl/alu_tmr_pkg.sv
// Shared constants for the TMR ALU sequencer: opcodes, FSM encoding, vote word layout.
// The optional fault counters are enabled with `define ALU_TMR_FAULT_CNT_EN.
package alu_tmr_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_VOTE   = 3'd2;
  localparam logic [2:0] ST_DROP   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam int RES_W    = 32;
  localparam int OUT_LSB  = 0;
  localparam int OUT_W    = 16;
  localparam int MUL_LSB  = 16;
  localparam int MUL_W    = 15;
  localparam int COUT_BIT = 31;

  // Fields the opcode does not define are zeroed so junk on them cannot split the vote.
  function automatic logic [RES_W-1:0] mask_word(input logic [2:0] op, input logic [15:0] out,
                                                 input logic [14:0] mul, input logic cout);
    logic [RES_W-1:0] w;
    w = '0;
    w[OUT_LSB +: OUT_W] = out;
    if (op == OP_MUL) w[MUL_LSB +: MUL_W] = mul;
    if ((op == OP_ADD) || (op == OP_SUB)) w[COUT_BIT] = cout;
    return w;
  endfunction

endpackage

// File: rtl/alu_tmr_voter.sv
// Combinational 2-of-3 word voter with per-replica disagreement mask.
module alu_tmr_voter
  import alu_tmr_pkg::*;
(
  input  logic [RES_W-1:0] w0,
  input  logic [RES_W-1:0] w1,
  input  logic [RES_W-1:0] w2,
  output logic [RES_W-1:0] vote,
  output logic             have_majority,
  output logic [2:0]       mask
);

  always_comb begin
    vote          = w0;
    have_majority = 1'b1;
    if ((w0 == w1) || (w0 == w2)) begin
      vote = w0;
    end else if (w1 == w2) begin
      vote = w1;
    end else begin
      have_majority = 1'b0;
    end
    mask = {w2 != vote, w1 != vote, w0 != vote};
  end

endmodule

// File: rtl/alu_tmr_sequencer.sv
// Issues one operation to three ALU replicas, waits a settle window, votes, retries on split.
// `define ALU_TMR_FAULT_CNT_EN adds cnt_clr and saturating per-replica fault counters.
module alu_tmr_sequencer
  import alu_tmr_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 1
`ifdef ALU_TMR_FAULT_CNT_EN
  ,
  parameter int CNT_W         = 8
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [2:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [14:0] rsp_mul_hi,
  output logic        rsp_cout,
  output logic        rsp_err,
  output logic [2:0]  rsp_fault_mask,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_dr,
  input  logic [15:0] alu0_out,
  input  logic [14:0] alu0_mul,
  input  logic        alu0_cout,
  input  logic [15:0] alu1_out,
  input  logic [14:0] alu1_mul,
  input  logic        alu1_cout,
  input  logic [15:0] alu2_out,
  input  logic [14:0] alu2_mul,
  input  logic        alu2_cout,
`ifdef ALU_TMR_FAULT_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] fault_cnt0,
  output logic [CNT_W-1:0] fault_cnt1,
  output logic [CNT_W-1:0] fault_cnt2,
`endif
  output logic [2:0]  fsm_state
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [1:0] RETRY_LIM   = 2'(MAX_RETRY);

  logic [2:0]       state;
  logic [7:0]       settle_cnt;
  logic [1:0]       retry_cnt;
  logic [RES_W-1:0] w0, w1, w2, vote;
  logic             have_majority;
  logic [2:0]       vote_mask;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.
  assign req_ready = (state == ST_IDLE) & ~reset;
  assign fsm_state = state;

  assign w0 = mask_word(alu_op, alu0_out, alu0_mul, alu0_cout);
  assign w1 = mask_word(alu_op, alu1_out, alu1_mul, alu1_cout);
  assign w2 = mask_word(alu_op, alu2_out, alu2_mul, alu2_cout);

  alu_tmr_voter u_voter (
    .w0            (w0),
    .w1            (w1),
    .w2            (w2),
    .vote          (vote),
    .have_majority (have_majority),
    .mask          (vote_mask)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      settle_cnt     <= '0;
      retry_cnt      <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_mul_hi     <= '0;
      rsp_cout       <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_fault_mask <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      alu_dr         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_op     <= req_op;
            alu_dr     <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            retry_cnt  <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 8'd1;
          if (settle_cnt == 8'd1) state <= ST_VOTE;
        end
        ST_VOTE: begin
          if (have_majority) begin
            rsp_result     <= vote[OUT_LSB +: OUT_W];
            rsp_mul_hi     <= vote[MUL_LSB +: MUL_W];
            rsp_cout       <= vote[COUT_BIT];
            rsp_fault_mask <= vote_mask;
            rsp_err        <= 1'b0;
            rsp_valid      <= 1'b1;
            alu_dr         <= 1'b0;
            state          <= ST_RESP;
          end else if (retry_cnt < RETRY_LIM) begin
            retry_cnt <= retry_cnt + 2'd1;
            alu_dr    <= 1'b0;
            state     <= ST_DROP;
          end else begin
            // Unresolvable split: report replica 0 and blame everyone.
            rsp_result     <= w0[OUT_LSB +: OUT_W];
            rsp_mul_hi     <= w0[MUL_LSB +: MUL_W];
            rsp_cout       <= w0[COUT_BIT];
            rsp_fault_mask <= 3'b111;
            rsp_err        <= 1'b1;
            rsp_valid      <= 1'b1;
            alu_dr         <= 1'b0;
            state          <= ST_RESP;
          end
        end
        ST_DROP: begin
          alu_dr     <= 1'b1;
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_SETTLE;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_TMR_FAULT_CNT_EN
  logic [CNT_W-1:0] cnt [3];
  logic             rsp_fire;

  assign rsp_fire   = (state == ST_RESP) & rsp_ready;
  assign fault_cnt0 = cnt[0];
  assign fault_cnt1 = cnt[1];
  assign fault_cnt2 = cnt[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else if (rsp_fire) begin
      for (int i = 0; i < 3; i++)
        if (rsp_fault_mask[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_tmr_sequencer.sv
// Self-checking bench for alu_tmr_sequencer: replica model per attempt, expected-result queue.
`timescale 1ns/1ps
module tb_alu_tmr_sequencer;
  import alu_tmr_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] req_a, req_b, rsp_result, alu_a, alu_b;
  logic [2:0]  req_op, alu_op, rsp_fault_mask, fsm_state;
  logic [14:0] rsp_mul_hi;
  logic        rsp_cout, rsp_err, alu_dr;
  logic [15:0] alu0_out, alu1_out, alu2_out;
  logic [14:0] alu0_mul, alu1_mul, alu2_mul;
  logic        alu0_cout, alu1_cout, alu2_cout;
`ifdef ALU_TMR_FAULT_CNT_EN
  logic        cnt_clr;
  logic [7:0]  fault_cnt0, fault_cnt1, fault_cnt2;
  logic [7:0]  exp_cnt [3];
`endif

  // Replica responses per attempt (0 = first issue, 1 = retry)
  logic [15:0] rep_out  [0:1][0:2];
  logic [14:0] rep_mul  [0:1][0:2];
  logic        rep_cout [0:1][0:2];
  logic        att;

  assign alu0_out = rep_out[att][0];  assign alu0_mul = rep_mul[att][0];  assign alu0_cout = rep_cout[att][0];
  assign alu1_out = rep_out[att][1];  assign alu1_mul = rep_mul[att][1];  assign alu1_cout = rep_cout[att][1];
  assign alu2_out = rep_out[att][2];  assign alu2_mul = rep_mul[att][2];  assign alu2_cout = rep_cout[att][2];

  alu_tmr_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_mul_hi(rsp_mul_hi), .rsp_cout(rsp_cout),
    .rsp_err(rsp_err), .rsp_fault_mask(rsp_fault_mask),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_dr(alu_dr),
    .alu0_out(alu0_out), .alu0_mul(alu0_mul), .alu0_cout(alu0_cout),
    .alu1_out(alu1_out), .alu1_mul(alu1_mul), .alu1_cout(alu1_cout),
    .alu2_out(alu2_out), .alu2_mul(alu2_mul), .alu2_cout(alu2_cout),
`ifdef ALU_TMR_FAULT_CNT_EN
    .cnt_clr(cnt_clr), .fault_cnt0(fault_cnt0), .fault_cnt1(fault_cnt1), .fault_cnt2(fault_cnt2),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q [$];  // {mask, err, cout, mul_hi, result}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [2:0] op, input logic [15:0] o,
                                           input logic [14:0] m, input logic c);
    return {((op == OP_ADD) || (op == OP_SUB)) ? c : 1'b0, (op == OP_MUL) ? m : 15'd0, o};
  endfunction

  // Expected response, latency and retry count for the replica table currently loaded
  task automatic predict(input logic [2:0] op, output logic [35:0] e, output int lat, output int drops);
    logic [31:0] w [3];
    logic [31:0] v;
    logic [2:0]  m;
    int          maj;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) w[i] = ref_word(op, rep_out[k][i], rep_mul[k][i], rep_cout[k][i]);
      maj = -1;
      for (int i = 0; i < 3; i++) begin
        int n = 0;
        for (int j = 0; j < 3; j++) if (w[i] == w[j]) n++;
        if (n >= 2 && maj < 0) maj = i;
      end
      if (maj >= 0) begin
        v = w[maj];
        for (int i = 0; i < 3; i++) m[i] = (w[i] != v);
        e = {m, 1'b0, v};
        lat = 3 + 4 * k;
        drops = k;
        return;
      end
    end
    e = {3'b111, 1'b1, w[0]};
    lat = 7;
    drops = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_rep(input int k, input int i, input logic [15:0] o, input logic [14:0] m, input logic c);
    rep_out[k][i] = o; rep_mul[k][i] = m; rep_cout[k][i] = c;
  endtask

  task automatic set_all(input logic [15:0] o, input logic [14:0] m, input logic c);
    for (int k = 0; k < 2; k++) for (int i = 0; i < 3; i++) set_rep(k, i, o, m, c);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input int hold);
    logic [35:0] e;
    int lat, drops, t0, n, seen_drops;
    predict(op, e, lat, drops);
    @(negedge clk);
    att = 1'b0;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(req_ready), 32'd1);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    t0 = cyc;
    chk("issue_a", 32'(alu_a), 32'(a));
    chk("issue_op", 32'(alu_op), 32'(op));
    seen_drops = 0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      if (!alu_dr) begin seen_drops++; att = 1'b1; end
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    chk("latency", 32'(cyc - t0), 32'(lat));
    chk("dr_drops", 32'(seen_drops), 32'(drops));
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk("hold_result", 32'(rsp_result), 32'(e[15:0]));
      chk("hold_mask", 32'(rsp_fault_mask), 32'(e[35:33]));
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    chk("result", 32'(rsp_result), 32'(e[15:0]));
    chk("mul_hi", 32'(rsp_mul_hi), 32'(e[30:16]));
    chk("cout", 32'(rsp_cout), 32'(e[31]));
    chk("err", 32'(rsp_err), 32'(e[32]));
    chk("mask", 32'(rsp_fault_mask), 32'(e[35:33]));
    rsp_ready = 1'b1;
    @(posedge clk);
`ifdef ALU_TMR_FAULT_CNT_EN
    for (int i = 0; i < 3; i++) if (e[33 + i] && exp_cnt[i] != 8'hFF) exp_cnt[i]++;
`endif
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("req_ready_after_hs", 32'(req_ready), 32'd1);
`ifdef ALU_TMR_FAULT_CNT_EN
    chk("cnt0", 32'(fault_cnt0), 32'(exp_cnt[0]));
    chk("cnt1", 32'(fault_cnt1), 32'(exp_cnt[1]));
    chk("cnt2", 32'(fault_cnt2), 32'(exp_cnt[2]));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] base, a, b;
    logic [14:0] m;
    logic        c;
    logic [2:0]  op;
    int          mode, j;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; att = 1'b0;
    set_all(16'h0, 15'h0, 1'b0);
`ifdef ALU_TMR_FAULT_CNT_EN
    cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_dr", 32'(alu_dr), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_alu_a", 32'(alu_a), 32'd0);

    // Plain add, all replicas agree
    set_all(16'h0007, 15'h0, 1'b0);
    run_op(16'h0003, 16'h0004, OP_ADD, 0);
    // Replica 1 wrong, outvoted without retry
    set_all(16'h0007, 15'h0, 1'b0);
    set_rep(0, 1, 16'h0008, 15'h0, 1'b0);
    run_op(16'h0003, 16'h0004, OP_ADD, 0);
    // Multiply, replica 2 high product disagrees
    set_all(16'h0000, 15'h0001, 1'b0);
    set_rep(0, 2, 16'h0000, 15'h0003, 1'b0);
    run_op(16'h0100, 16'h0100, OP_MUL, 0);
    // NOT with junk on mul/cout lines that must be ignored
    set_all(16'hFF00, 15'h0, 1'b0);
    set_rep(0, 0, 16'hFF00, 15'h0001, 1'b1);
    set_rep(0, 1, 16'hFF00, 15'h0002, 1'b0);
    set_rep(0, 2, 16'hFF00, 15'h7FFF, 1'b1);
    run_op(16'h00FF, 16'h0000, OP_NOT, 0);
    // Split first time, agree on retry
    set_all(16'h1234, 15'h0, 1'b0);
    set_rep(0, 0, 16'h1111, 15'h0, 1'b0);
    set_rep(0, 1, 16'h2222, 15'h0, 1'b0);
    set_rep(0, 2, 16'h3333, 15'h0, 1'b0);
    run_op(16'h1234, 16'hFFFF, OP_AND, 0);
    // Split on both attempts: error, replica 0 reported
    set_rep(0, 0, 16'h0001, 15'h0, 1'b0);
    set_rep(0, 1, 16'h0002, 15'h0, 1'b0);
    set_rep(0, 2, 16'h0003, 15'h0, 1'b0);
    set_rep(1, 0, 16'hAAAA, 15'h0, 1'b0);
    set_rep(1, 1, 16'h5555, 15'h0, 1'b0);
    set_rep(1, 2, 16'h0F0F, 15'h0, 1'b0);
    run_op(16'hAAAA, 16'h0000, OP_OR, 0);
    // Consumer stalls for 5 cycles
    set_all(16'h0007, 15'h0, 1'b1);
    run_op(16'hFFFF, 16'h0008, OP_ADD, 5);

    // Random traffic with occasional single-replica faults and first-attempt splits
    for (int t = 0; t < 24; t++) begin
      op   = 3'($urandom_range(0, 7));
      a    = 16'($urandom_range(0, 65535));
      b    = 16'($urandom_range(0, 65535));
      base = 16'($urandom_range(0, 65535));
      m    = 15'($urandom_range(0, 32767));
      c    = 1'($urandom_range(0, 1));
      set_all(base, m, c);
      mode = $urandom_range(0, 3);
      j    = $urandom_range(0, 2);
      if (mode == 1) set_rep(0, j, base ^ (16'h1 << $urandom_range(0, 15)), m, c);
      if (mode == 2) set_rep(0, j, base, ~m, ~c);
      if (mode == 3) begin
        set_rep(0, 1, base ^ 16'h0001, m, c);
        set_rep(0, 2, base ^ 16'h0002, m, c);
      end
      run_op(a, b, op, $urandom_range(0, 2));
    end

    // Reset in the middle of the settle window aborts the operation
    set_all(16'h4321, 15'h0, 1'b0);
    @(negedge clk);
    req_a = 16'h1; req_b = 16'h2; req_op = OP_SUB; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_dr_settle", 32'(alu_dr), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_alu_dr", 32'(alu_dr), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_result", 32'(rsp_result), 32'd0);
    chk("abort_rsp_mask", 32'(rsp_fault_mask), 32'd0);
    chk("abort_rsp_err", 32'(rsp_err), 32'd0);
    chk("abort_rsp_cout", 32'(rsp_cout), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
`ifdef ALU_TMR_FAULT_CNT_EN
    for (int i = 0; i < 3; i++) exp_cnt[i] = '0;
    chk("abort_cnt0", 32'(fault_cnt0), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end

    // Recovery after abort, with a fault so the counters have something to clear
    set_all(16'h0042, 15'h0, 1'b0);
    set_rep(0, 0, 16'h0043, 15'h0, 1'b0);
    run_op(16'h0040, 16'h0002, OP_ADD, 1);
`ifdef ALU_TMR_FAULT_CNT_EN
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = '0;
    chk("clr_cnt0", 32'(fault_cnt0), 32'd0);
    chk("clr_cnt1", 32'(fault_cnt1), 32'd0);
    chk("clr_cnt2", 32'(fault_cnt2), 32'd0);
`endif
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
